// File: rtl/load_store_unit_if.sv
// memory_bus: dispatch/busy memory bus between the load/store unit (CONSUMER) and the memory system (RESPONDER).
interface memory_bus;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [1:0]  mem_width;
    logic        dispatch_read;
    logic        dispatch_write;
    logic        busy;

    modport CONSUMER (
        output addr, write_data, mem_width, dispatch_read, dispatch_write,
        input  read_data, busy
    );

    modport RESPONDER (
        input  addr, write_data, mem_width, dispatch_read, dispatch_write,
        output read_data, busy
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store initiator on memory_bus with fault screening and load extension.
// Optional WAIT-state abort after TIMEOUT_CYCLES when LSU_TIMEOUT_EN is defined.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_is_store_in,
    input  logic [2:0]  req_funct3_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    output logic        resp_valid_out,
    output logic [31:0] resp_rdata_out,
    output logic [1:0]  resp_fault_out,
    memory_bus.CONSUMER bus
);
    localparam logic [1:0] BYTE = 2'b00;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state;
    logic        is_store;
    logic [2:0]  funct3;
    logic        illegal;
    logic        misaligned;
    logic [31:0] load_data;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
`endif

    assign req_ready_out = (state == IDLE) && !bus.busy;

    always_comb begin
        illegal    = req_is_store_in ? (req_funct3_in[2] || req_funct3_in == 3'b011)
                                     : (req_funct3_in inside {3'b011, 3'b110, 3'b111});
        misaligned = (req_funct3_in[1:0] == 2'b01 && req_addr_in[0])
                  || (req_funct3_in[1:0] == 2'b10 && req_addr_in[1:0] != 2'b00);
        // funct3[2] selects zero-extension for LBU/LHU
        load_data  = funct3[1:0] == 2'b00 ? {{24{!funct3[2] && bus.read_data[7]}}, bus.read_data[7:0]}
                   : funct3[1:0] == 2'b01 ? {{16{!funct3[2] && bus.read_data[15]}}, bus.read_data[15:0]}
                   : bus.read_data;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state              <= IDLE;
            is_store           <= 1'b0;
            funct3             <= 3'b000;
            resp_valid_out     <= 1'b0;
            resp_rdata_out     <= 32'h0;
            resp_fault_out     <= 2'b00;
            bus.addr           <= 32'h0;
            bus.write_data     <= 32'h0;
            bus.mem_width      <= BYTE;
            bus.dispatch_read  <= 1'b0;
            bus.dispatch_write <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt                <= '0;
`endif
        end else begin
            resp_valid_out     <= 1'b0;
            bus.dispatch_read  <= 1'b0;
            bus.dispatch_write <= 1'b0;
            case (state)
                IDLE: if (req_valid_in && req_ready_out) begin
                    if (illegal || misaligned) begin
                        resp_valid_out <= 1'b1;
                        resp_rdata_out <= 32'h0;
                        resp_fault_out <= illegal ? 2'b10 : 2'b01;
                    end else begin
                        bus.addr           <= req_addr_in;
                        bus.write_data     <= req_wdata_in;
                        bus.mem_width      <= req_funct3_in[1:0];
                        bus.dispatch_read  <= !req_is_store_in;
                        bus.dispatch_write <= req_is_store_in;
                        is_store           <= req_is_store_in;
                        funct3             <= req_funct3_in;
                        state              <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef LSU_TIMEOUT_EN
                    cnt   <= '0;
`endif
                end
                WAIT: if (!bus.busy) begin
                    resp_valid_out <= 1'b1;
                    resp_rdata_out <= is_store ? 32'h0 : load_data;
                    resp_fault_out <= 2'b00;
                    state          <= IDLE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    resp_valid_out <= 1'b1;
                    resp_rdata_out <= 32'h0;
                    resp_fault_out <= 2'b11;
                    state          <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed spec scenarios plus randomized traffic against a byte-array reference model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_fault;

    memory_bus bus ();

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .req_valid_in(req_valid), .req_ready_out(req_ready),
        .req_is_store_in(req_is_store), .req_funct3_in(req_funct3),
        .req_addr_in(req_addr), .req_wdata_in(req_wdata),
        .resp_valid_out(resp_valid), .resp_rdata_out(resp_rdata), .resp_fault_out(resp_fault),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Responder: busy from the dispatch cycle until lat cycles later, byte RAM with addressed byte in bits [7:0]
    bit [7:0]    ram [4096];
    bit [7:0]    ref_mem [4096];
    int          lat = 0;
    int          busy_cnt = 0;
    logic [31:0] rd_q = 32'h0;

    assign bus.busy      = bus.dispatch_read || bus.dispatch_write || busy_cnt != 0;
    assign bus.read_data = rd_q;

    always @(posedge clk) begin
        if (bus.dispatch_write)
            for (int i = 0; i < (1 << bus.mem_width); i++)
                ram[(int'(bus.addr[11:0]) + i) & 4095] = bus.write_data[8*i +: 8];
        if (bus.dispatch_read)
            for (int i = 0; i < 4; i++)
                rd_q[8*i +: 8] <= ram[(int'(bus.addr[11:0]) + i) & 4095];
        busy_cnt <= (bus.dispatch_read || bus.dispatch_write) ? lat : (busy_cnt != 0 ? busy_cnt - 1 : 0);
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] flt);
        int     sz;
        int     base;
        bit     ill;
        longint v;
        sz   = 1 << f3[1:0];
        base = int'(a[11:0]);
        ill  = st ? (f3 inside {[3:7]}) : (f3 inside {3, 6, 7});
        rd   = 32'h0;
        v    = 0;
        if (ill) flt = 2'd2;
        else if (base % sz != 0) flt = 2'd1;
        else begin
            flt = 2'd0;
            for (int i = 0; i < sz; i++) begin
                if (st) ref_mem[(base + i) & 4095] = wd[8*i +: 8];
                else v += longint'(ref_mem[(base + i) & 4095]) << (8 * i);
            end
            if (!st && !f3[2] && sz < 4 && v >= (64'sd1 << (8 * sz - 1))) v -= (64'sd1 << (8 * sz));
            if (!st) rd = v[31:0];
        end
    endfunction

    // Called at a negedge; returns at the negedge where resp_valid is seen
    task automatic xfer(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int waited);
        logic [31:0] ex_rd;
        logic [1:0]  ex_f;
        int          k, n_disp, disp_at;
        logic        dir_w;
        logic [1:0]  w;
        model(st, f3, a, wd, ex_rd, ex_f);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        waited = 0;
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("accept", 32'(req_ready), 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        k = 0; n_disp = 0; disp_at = 0; dir_w = 1'b0; w = 2'b00;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) req_valid = 1'b0;
            if (bus.dispatch_read || bus.dispatch_write) begin
                n_disp++;
                disp_at = k;
                dir_w = bus.dispatch_write;
                w = bus.mem_width;
            end
        end while (!resp_valid && k < 200);
        chk("resp_seen", 32'(resp_valid), 32'd1);
        chk("rdata", resp_rdata, ex_rd);
        chk("fault", 32'(resp_fault), 32'(ex_f));
        chk("dispatches", 32'(n_disp), 32'(ex_f == 2'd0));
        chk("resp_latency", 32'(k), ex_f == 2'd0 ? 32'(lat + 3) : 32'd1);
        if (ex_f == 2'd0) begin
            chk("dispatch_cycle", 32'(disp_at), 32'd1);
            chk("dispatch_dir", 32'(dir_w), 32'(st));
            chk("mem_width", 32'(w), 32'(f3[1:0]));
        end
    endtask

    initial begin
        int   wt, k;
        bit   seen;
        bit   st;
        logic [2:0] f3;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_fault", 32'(resp_fault), 32'd0);
        chk("rst_addr", bus.addr, 32'h0);
        chk("rst_wdata", bus.write_data, 32'h0);
        chk("rst_width", 32'(bus.mem_width), 32'd0);
        chk("rst_dispatch", 32'({bus.dispatch_read, bus.dispatch_write}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        lat = 2;
        xfer(1'b1, 3'b010, 32'h1000_0010, 32'h3412_FF80, wt);
        xfer(1'b0, 3'b010, 32'h1000_0010, 32'h0, wt); chk("t1_lw", resp_rdata, 32'h3412_FF80);
        xfer(1'b0, 3'b000, 32'h1000_0010, 32'h0, wt); chk("t1_lb", resp_rdata, 32'hFFFF_FF80);
        xfer(1'b0, 3'b100, 32'h1000_0010, 32'h0, wt); chk("t1_lbu", resp_rdata, 32'h0000_0080);
        xfer(1'b0, 3'b101, 32'h1000_0010, 32'h0, wt); chk("t1_lhu", resp_rdata, 32'h0000_FF80);

        xfer(1'b1, 3'b001, 32'h1000_0020, 32'hAAAA_BEEF, wt);
        xfer(1'b0, 3'b010, 32'h1000_0020, 32'h0, wt); chk("t2_lw", resp_rdata, 32'h0000_BEEF);

        xfer(1'b0, 3'b010, 32'h1000_0002, 32'h0, wt); chk("t3_fault", 32'(resp_fault), 32'd1);
        xfer(1'b0, 3'b011, 32'h1000_0010, 32'h0, wt); chk("t4_ld_fault", 32'(resp_fault), 32'd2);
        xfer(1'b1, 3'b110, 32'h1000_0010, 32'h1234, wt); chk("t4_st_fault", 32'(resp_fault), 32'd2);

        lat = 1;
        xfer(1'b0, 3'b010, 32'h1000_0010, 32'h0, wt);
        xfer(1'b0, 3'b000, 32'h1000_0011, 32'h0, wt);
        chk("b2b_accept_wait", 32'(wt), 32'd0);

        // Reset while WAIT is in progress
        lat = 12;
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1000_0010;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("rst_mid_dispatch", 32'({bus.dispatch_read, bus.dispatch_write}), 32'd0);
        chk("rst_mid_resp", 32'(resp_valid), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_release_ready", 32'(req_ready), 32'd0);
        seen = 1'b0; k = 0;
        while (bus.busy && k < 50) begin
            @(negedge clk);
            k++;
            seen |= resp_valid;
        end
        chk("rst_no_resp", 32'(seen), 32'd0);
        chk("rst_ready_after_busy", 32'(req_ready), 32'd1);

`ifdef LSU_TIMEOUT_EN
        lat = 200;
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1000_0010;
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            req_valid = 1'b0;
        end while (!resp_valid && k < 40);
        chk("to_latency", 32'(k), 32'd10);
        chk("to_fault", 32'(resp_fault), 32'd3);
        chk("to_rdata", resp_rdata, 32'h0);
        chk("to_ready_busy", 32'(req_ready), 32'd0);
        k = 0;
        while (bus.busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("to_ready_idle", 32'(req_ready), 32'd1);
`endif

        for (int n = 0; n < 200; n++) begin
            lat = $urandom_range(0, 3);
            st  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            xfer(st, f3, 32'h1000_0000 + 32'($urandom_range(64, 4091)), $urandom, wt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
